dma_mem_bridge: RTL and testbench

Memory-side responder for the matrix accelerator's DMA port. It accepts one-word DMA read and write requests from `matrix_accelerator`. Each request becomes a single classic Wishbone master cycle to system memory. The block returns read data and a one-cycle `dma_ack` to the accelerator, and reports bus errors, timeouts and misaligned accesses.

---
 rtl/dma_mem_bridge.sv | 131 +++++++++++++
 tb/tb_dma_mem_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_bridge.sv
// DMA-to-Wishbone bridge: turns one-word DMA requests from the matrix accelerator
// into classic Wishbone cycles, with timeout, sticky error reporting and transfer counters.
module dma_mem_bridge #(
    parameter logic [15:0] TIMEOUT  = 16'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        err_clr,
    output logic        err_o,
    output logic [1:0]  err_code,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [1:0] CODE_BUS = 2'd1, CODE_TMO = 2'd2, CODE_MIS = 2'd3;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, ok_q;
    logic [15:0] tcnt;
    logic        ev_ok, ev_err;
    logic [1:0]  ev_code;
    logic        cur_we, in_bus;

    // In IDLE the request is not latched yet, so a misaligned response uses the live dma_we.
    assign cur_we = (state == IDLE) ? dma_we : we_q;
    assign in_bus = (state == BUS);

    always_comb begin
        state_nxt = state;
        ev_ok     = 1'b0;
        ev_err    = 1'b0;
        ev_code   = 2'd0;
        case (state)
            IDLE: if (dma_req) begin
                if (dma_addr[1:0] != 2'b00) begin
                    state_nxt = RESP;
                    ev_err    = 1'b1;
                    ev_code   = CODE_MIS;
                end else begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    state_nxt = RESP;
                    ev_ok     = 1'b1;
                end else if (wbm_err_i) begin
                    state_nxt = RESP;
                    ev_err    = 1'b1;
                    ev_code   = CODE_BUS;
                end else if (tcnt == TIMEOUT - 16'd1) begin
                    state_nxt = RESP;
                    ev_err    = 1'b1;
                    ev_code   = CODE_TMO;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            ok_q     <= 1'b0;
            tcnt     <= '0;
            rd_count <= '0;
            wr_count <= '0;
            err_o    <= 1'b0;
            err_code <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && dma_req) begin
                addr_q  <= dma_addr;
                we_q    <= dma_we;
                wdata_q <= dma_wdata;
            end
            tcnt <= in_bus ? tcnt + 16'd1 : 16'd0;
            if (state != RESP && state_nxt == RESP) begin
                ok_q <= ev_ok;
                if (cur_we)     rdata_q <= '0;
                else if (ev_ok) rdata_q <= wbm_dat_i;
                else            rdata_q <= ERR_DATA;
            end
            // Counters advance on leaving RESP, independent of whether the ack was delivered.
            if (state == RESP && ok_q) begin
                if (we_q) wr_count <= wr_count + 16'd1;
                else      rd_count <= rd_count + 16'd1;
            end
            if (ev_err) begin
                err_o <= 1'b1;
                if (!err_o || err_clr) err_code <= ev_code;
            end else if (err_clr) begin
                err_o    <= 1'b0;
                err_code <= '0;
            end
        end
    end

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus & we_q;
    assign wbm_adr_o = in_bus ? addr_q : 32'd0;
    assign wbm_dat_o = in_bus ? wdata_q : 32'd0;
    assign wbm_sel_o = in_bus ? 4'hF : 4'h0;
    assign dma_ack   = (state == RESP) && dma_req;
    assign dma_rdata = dma_ack ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dma_mem_bridge.sv
// Directed + randomized bench for dma_mem_bridge with a behavioural Wishbone memory
// and a transaction-level reference model for latency, data, counters and error flags.
module tb_dma_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        dma_req, dma_we, err_clr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i, err_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic [1:0]  err_code;
    logic [15:0] rd_count, wr_count;

    always #5 clk = ~clk;

    dma_mem_bridge #(.TIMEOUT(16'd8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .err_clr(err_clr), .err_o(err_o), .err_code(err_code),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    // Memory: mode 0 acks, 1 errors, 2 never responds; response after ws wait states.
    int          ws = 0, mode = 0, scnt;
    logic [31:0] mem_word = '0;
    int          stb_cnt = 0, cs_bad = 0, sel_bad = 0;
    logic [31:0] log_adr[$], log_dat[$];
    logic        log_we[$];

    assign wbm_ack_i = wbm_stb_o && mode == 0 && scnt == ws;
    assign wbm_err_i = wbm_stb_o && mode == 1 && scnt == ws;
    assign wbm_dat_i = mem_word;

    always @(posedge clk or posedge reset) begin
        if (reset) scnt <= 0;
        else if (wbm_stb_o && !wbm_ack_i && !wbm_err_i) scnt <= scnt + 1;
        else scnt <= 0;
    end

    always @(posedge clk) begin
        if (wbm_stb_o) stb_cnt <= stb_cnt + 1;
        if (wbm_cyc_o !== wbm_stb_o) cs_bad <= cs_bad + 1;
        if (wbm_stb_o && wbm_sel_o !== 4'hF) sel_bad <= sel_bad + 1;
        if (wbm_ack_i) begin
            log_adr.push_back(wbm_adr_o);
            log_dat.push_back(wbm_dat_o);
            log_we.push_back(wbm_we_o);
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request (caller is at a negedge) and waits for dma_ack; cyc=200 means none came.
    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd);
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        cyc = 0; rd = 'x;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dma_ack) begin
                rd = dma_rdata;
                break;
            end
        end
    endtask

    task automatic wait_stb(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wbm_stb_o) seen = 1'b1;
        end
    endtask

    // Reference model state
    logic [15:0] rd_exp = '0, wr_exp = '0;
    logic        err_exp = 1'b0;
    logic [1:0]  code_exp = '0;

    // kind: 0 ok, 1 bus error, 2 timeout, 3 misaligned
    task automatic model(input int kind, input logic we);
        if (kind == 0) begin
            if (we) wr_exp = wr_exp + 16'd1;
            else    rd_exp = rd_exp + 16'd1;
        end else begin
            if (!err_exp) code_exp = 2'(kind);
            err_exp = 1'b1;
        end
    endtask

    function automatic int exp_lat(input int kind, input int w);
        if (kind == 3) return 1;
        if (kind == 2) return 8 + 1;
        return 2 + w;
    endfunction

    initial begin
        int cyc, s0, bad_lat, bad_rd, bad_log, acks, n0;
        logic [31:0] rd, d;
        logic [31:0] exp_d[64];
        bit seen;

        reset = 1'b1; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; err_clr = 1'b0;
        @(negedge clk);
        chk("reset_dma", {32'd0, dma_rdata, 31'd0, dma_ack}, 64'd0);
        chk("reset_wb_ctl", {57'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 64'd0);
        chk("reset_wb_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'd0);
        chk("reset_err_cnt", {29'd0, err_o, err_code, rd_count, wr_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read
        ws = 0; mode = 0; mem_word = 32'h12345678;
        xfer(1'b0, 32'h100, 32'h0, cyc, rd);
        chk("rd0_latency", 64'(cyc), 64'd2);
        chk("rd0_data", 64'(rd), 64'h12345678);
        dma_req = 1'b0;
        model(0, 1'b0);
        @(negedge clk);
        chk("rd0_count", 64'(rd_count), 64'(rd_exp));
        chk("rd0_wb_adr", {31'd0, log_we[$], log_adr[$]}, 64'h100);

        // Burst of 64 writes, 2 wait states, dma_req held high throughout
        ws = 2; bad_lat = 0; bad_rd = 0; n0 = log_adr.size();
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            exp_d[i] = d;
            xfer(1'b1, 32'h2000 + 32'(i * 4), d, cyc, rd);
            if (cyc != (i == 0 ? 4 : 5)) bad_lat++;
            if (rd !== 32'd0) bad_rd++;
            model(0, 1'b1);
        end
        dma_req = 1'b0;
        @(negedge clk);
        bad_log = 0;
        for (int i = 0; i < 64; i++)
            if (log_adr[n0 + i] !== 32'h2000 + 32'(i * 4) || log_dat[n0 + i] !== exp_d[i] || log_we[n0 + i] !== 1'b1)
                bad_log++;
        chk("burst_latency_errs", 64'(bad_lat), 64'd0);
        chk("burst_rdata_errs", 64'(bad_rd), 64'd0);
        chk("burst_wb_log_size", 64'(log_adr.size() - n0), 64'd64);
        chk("burst_wb_log_errs", 64'(bad_log), 64'd0);
        chk("burst_wr_count", 64'(wr_count), 64'(wr_exp));
        chk("burst_err_o", 64'(err_o), 64'd0);

        // Timeout on a read
        mode = 2; s0 = stb_cnt;
        xfer(1'b0, 32'h300, 32'h0, cyc, rd);
        chk("tmo_latency", 64'(cyc), 64'(exp_lat(2, 0)));
        chk("tmo_rdata", 64'(rd), 64'hDEADBEEF);
        dma_req = 1'b0;
        model(2, 1'b0);
        @(negedge clk);
        chk("tmo_stb_cycles", 64'(stb_cnt - s0), 64'd8);
        chk("tmo_err", {err_o, err_code}, {err_exp, code_exp});
        chk("tmo_rd_count", 64'(rd_count), 64'(rd_exp));
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        err_exp = 1'b0; code_exp = 2'd0;
        chk("tmo_clr", {err_o, err_code}, 3'b000);

        // Misaligned write, then a bus-error read keeps the first code
        mode = 0; s0 = stb_cnt;
        xfer(1'b1, 32'h103, 32'hCAFE0001, cyc, rd);
        chk("mis_latency", 64'(cyc), 64'd1);
        dma_req = 1'b0;
        model(3, 1'b1);
        @(negedge clk);
        chk("mis_no_cycle", 64'(stb_cnt - s0), 64'd0);
        chk("mis_err", {err_o, err_code}, {err_exp, code_exp});
        chk("mis_wr_count", 64'(wr_count), 64'(wr_exp));
        mode = 1; ws = 1;
        xfer(1'b0, 32'h104, 32'h0, cyc, rd);
        chk("berr_latency", 64'(cyc), 64'd3);
        chk("berr_rdata", 64'(rd), 64'hDEADBEEF);
        dma_req = 1'b0;
        model(1, 1'b0);
        @(negedge clk);
        chk("berr_keeps_code", {err_o, err_code}, {err_exp, code_exp});
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        err_exp = 1'b0; code_exp = 2'd0;
        chk("clr_after_berr", {err_o, err_code}, 3'b000);

        // Bus error sets code 1; a misaligned error in the same cycle as err_clr reloads the code
        xfer(1'b0, 32'h108, 32'h0, cyc, rd);
        dma_req = 1'b0;
        model(1, 1'b0);
        @(negedge clk);
        chk("berr_code1", {err_o, err_code}, {err_exp, code_exp});
        err_clr = 1'b1;
        xfer(1'b0, 32'h10A, 32'h0, cyc, rd);
        err_clr = 1'b0; dma_req = 1'b0;
        err_exp = 1'b1; code_exp = 2'd3;
        @(negedge clk);
        chk("clr_vs_error", {err_o, err_code}, {err_exp, code_exp});
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        err_exp = 1'b0; code_exp = 2'd0;

        // Withdrawn request: cycle finishes, no ack, counter still advances
        mode = 0; ws = 3; mem_word = $urandom; n0 = log_adr.size();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h400;
        wait_stb(seen);
        chk("wd_reached_bus", 64'(seen), 64'd1);
        dma_req = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (dma_ack) acks++;
        end
        model(0, 1'b0);
        chk("wd_no_ack", 64'(acks), 64'd0);
        chk("wd_wb_done", {31'd0, log_adr.size() == n0 + 1, log_adr[$]}, {32'd1, 32'h400});
        chk("wd_rd_count", 64'(rd_count), 64'(rd_exp));

        // Randomized mix against the model
        bad_lat = 0; bad_rd = 0;
        for (int i = 0; i < 40; i++) begin
            int r, kind;
            logic we;
            logic [31:0] a, exp_r;
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
                err_exp = 1'b0; code_exp = 2'd0;
            end
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 3 : (r == 1) ? 1 : 0;
            we = 1'($urandom_range(0, 1));
            ws = $urandom_range(0, 3);
            mode = (kind == 1) ? 1 : 0;
            mem_word = $urandom;
            a = {$urandom, 2'b00};
            a = a[31:0];
            if (kind == 3) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            exp_r = we ? 32'd0 : (kind == 0 ? mem_word : 32'hDEADBEEF);
            xfer(we, a, d, cyc, rd);
            if (cyc != exp_lat(kind, ws)) bad_lat++;
            if (rd !== exp_r) bad_rd++;
            dma_req = 1'b0;
            model(kind, we);
            @(negedge clk);
            chk("rand_state", {27'd0, err_o, err_code, rd_count, wr_count}, {27'd0, err_exp, code_exp, rd_exp, wr_exp});
        end
        chk("rand_latency_errs", 64'(bad_lat), 64'd0);
        chk("rand_rdata_errs", 64'(bad_rd), 64'd0);

        // Asynchronous reset in the middle of a Wishbone cycle
        mode = 0; ws = 6;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h500; dma_wdata = 32'h55AA55AA;
        wait_stb(seen);
        chk("rst_mid_reached_bus", 64'(seen), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_wb_ctl", {57'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 64'd0);
        chk("rst_mid_wb_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'd0);
        chk("rst_mid_state", {29'd0, err_o, err_code, rd_count, wr_count}, 64'd0);
        chk("rst_mid_dma", {31'd0, dma_ack, dma_rdata}, 64'd0);
        dma_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rd_exp = '0; wr_exp = '0; err_exp = 1'b0; code_exp = 2'd0;
        @(negedge clk);
        ws = 0; mem_word = 32'h0BADF00D;
        xfer(1'b0, 32'h600, 32'h0, cyc, rd);
        chk("post_rst_latency", 64'(cyc), 64'd2);
        chk("post_rst_rdata", 64'(rd), 64'h0BADF00D);
        dma_req = 1'b0;
        model(0, 1'b0);
        @(negedge clk);
        chk("post_rst_counts", {rd_count, wr_count}, {rd_exp, wr_exp});

        chk("cyc_stb_together", 64'(cs_bad), 64'd0);
        chk("sel_all_bytes", 64'(sel_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
